rf_scoreboard_mp: RTL

Parametrised successor to the pipeline's general register file, sitting in the decode stage.
- Generalised in data width, depth and read-port count.
- Adds optional write-to-read bypass, configurable hardwired zero register and a commit trace.
- Adds a per-register pending-write scoreboard that hazard logic uses to stall on in-flight producers.
- Writes occur at writeback; scoreboard increments occur at issue.

---
 rtl/rf_scoreboard_mp.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rf_scoreboard_mp.sv
// Multi-port decode-stage register file with write-to-read bypass, hardwired zero
// register, per-register pending-write scoreboard and optional commit trace.
module rf_scoreboard_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 3,
   parameter int PEND_W   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int TRACE    = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [31:0]                wr_pc,
   input  logic                       iss_en,
   input  logic [ADDR_W-1:0]          iss_addr,
   input  logic                       flush,
   output logic                       pend_ovf
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [PEND_W-1:0] cnt_q  [DEPTH];
   logic [PEND_W-1:0] cnt_d  [DEPTH];
   logic              pend_ovf_q, pend_ovf_d;

   logic wr_ok, iss_ok, dec_ok, same_reg;

   // Register 0 is immune to both writes and issues when zero-protected.
   assign wr_ok    = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
   assign iss_ok   = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));
   assign dec_ok   = wr_ok && (cnt_q[wr_addr] != '0);
   assign same_reg = dec_ok && iss_ok && (wr_addr == iss_addr);

   always_comb begin
      regs_d = regs_q;
      cnt_d  = cnt_q;
      pend_ovf_d = pend_ovf_q;
      if (wr_ok) begin
         regs_d[wr_addr] = wr_data;
      end
      if (flush) begin
         for (int r = 0; r < DEPTH; r++) begin
            cnt_d[r] = '0;
         end
      end else if (!same_reg) begin
         if (dec_ok) begin
            cnt_d[wr_addr] = cnt_q[wr_addr] - PEND_W'(1);
         end
         if (iss_ok) begin
            if (cnt_q[iss_addr] == CNT_MAX) begin
               pend_ovf_d = 1'b1;
            end else begin
               cnt_d[iss_addr] = cnt_q[iss_addr] + PEND_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < DEPTH; r++) begin
            regs_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
         pend_ovf_q <= 1'b0;
      end else begin
         for (int r = 0; r < DEPTH; r++) begin
            regs_q[r] <= regs_d[r];
            cnt_q[r]  <= cnt_d[r];
         end
         pend_ovf_q <= pend_ovf_d;
      end
   end

   assign pend_ovf = pend_ovf_q;

   generate
      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] ra;
         logic              ra_zero, hit, dec_here;
         logic [DATA_W-1:0] data;
         logic              busy;

         assign ra       = rd_addr[gi*ADDR_W +: ADDR_W];
         assign ra_zero  = (ZERO_REG != 0) && (ra == '0);
         assign hit      = (BYPASS != 0) && wr_ok  && (wr_addr == ra);
         // A retiring writer whose data is being forwarded no longer counts as pending.
         assign dec_here = (BYPASS != 0) && dec_ok && (wr_addr == ra);

         always_comb begin
            data = '0;
            busy = 1'b0;
            if (reset && !ra_zero) begin
               data = hit ? wr_data : regs_q[ra];
               busy = (cnt_q[ra] - PEND_W'(dec_here)) != '0;
            end
         end

         assign rd_data[gi*DATA_W +: DATA_W] = data;
         assign rd_busy[gi]                  = busy;
      end
   endgenerate

`ifndef SYNTHESIS
   generate
      if (TRACE != 0) begin : g_trace
         always @(posedge clk) begin
            if (reset && wr_ok) begin
               $display("@%h: $%d <= %h", wr_pc, wr_addr, wr_data);
            end
         end
      end
   endgenerate
`endif
endmodule
